l1a_trigger_buffer: RTL and testbench

- Parametrised successor to the plain l1a register in the RTL top: a complete Level-1-Accept front end.
- Keeps a bunch-crossing (BX) counter aligned to orbit markers and an event counter.
- Enforces a minimum trigger spacing.
- Queues each accepted trigger as an {event, BX} record in a FIFO, drained with a valid/ready handshake by the readout logic in the top module.

---
 rtl/l1a_trigger_buffer.sv | 129 ++++++++++++
 tb/tb_l1a_trigger_buffer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/l1a_trigger_buffer.sv
// l1a_trigger_buffer: Level-1-Accept front end.
// Keeps an orbit-aligned BX counter and an event counter, enforces a minimum
// trigger spacing, and queues {evt, bx} records in a first-word-fall-through
// FIFO drained by a valid/ready handshake.
// Optional: define L1A_DROP_CNT_EN to build a saturating rejected-trigger
// counter on 'dropped'; otherwise 'dropped' is tied to 0.
module l1a_trigger_buffer #(
    parameter int BX_W        = 12,
    parameter int BX_MAX      = 3563,
    parameter int EVT_W       = 24,
    parameter int DEPTH       = 16,
    parameter int MIN_SPACING = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bc0,
    input  logic                   ecr,
    input  logic                   l1a,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EVT_W-1:0]       out_evt,
    output logic [BX_W-1:0]        out_bx,
    output logic                   synced,
    output logic                   bx_err,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic [15:0]            dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int HW = (MIN_SPACING > 2) ? $clog2(MIN_SPACING) : 1;
    localparam logic [BX_W-1:0] BX_LAST   = BX_W'(BX_MAX);
    localparam logic [HW-1:0]   HOLD_LOAD = (MIN_SPACING > 1) ? HW'(MIN_SPACING - 1) : '0;
    localparam logic [AW:0]     CNT_FULL  = (AW+1)'(DEPTH);

    typedef enum logic {UNSYNC, SYNC} state_t;

    state_t                 state;
    logic [BX_W-1:0]        bx;
    logic [EVT_W-1:0]       evt;
    logic [HW-1:0]          holdoff;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [EVT_W+BX_W-1:0]  mem [DEPTH];
    logic [EVT_W+BX_W-1:0]  head;
    logic [EVT_W-1:0]       rec_evt;
    logic                   accept, pop;

    // A pop in the same cycle does not make room: full is judged on the
    // registered occupancy only.
    assign full      = (count == CNT_FULL);
    assign out_valid = (count != '0);
    assign accept    = l1a & (state == SYNC) & (holdoff == '0) & ~full;
    assign pop       = out_valid & out_ready;
    // ecr coincident with an accept stamps the record with event 0
    assign rec_evt   = ecr ? '0 : evt;
    assign head      = mem[rd_ptr];
    assign out_evt   = out_valid ? head[EVT_W+BX_W-1:BX_W] : '0;
    assign out_bx    = out_valid ? head[BX_W-1:0] : '0;

    // Orbit sync FSM with BX counter and sticky misalignment flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= UNSYNC;
            synced <= 1'b0;
            bx_err <= 1'b0;
            bx     <= '0;
        end else begin
            if (bc0 || bx == BX_LAST) bx <= '0;
            else                      bx <= bx + BX_W'(1);
            case (state)
                UNSYNC: if (bc0) begin
                    state  <= SYNC;
                    synced <= 1'b1;
                end
                SYNC: if (bc0 && bx != BX_LAST) bx_err <= 1'b1;
                default: begin
                    state  <= UNSYNC;
                    synced <= 1'b0;
                end
            endcase
        end
    end

    // Event counter and trigger-spacing holdoff
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt     <= '0;
            holdoff <= '0;
        end else begin
            if (accept)    evt <= rec_evt + EVT_W'(1);
            else if (ecr)  evt <= '0;
            if (accept)               holdoff <= HOLD_LOAD;
            else if (holdoff != '0)   holdoff <= holdoff - HW'(1);
        end
    end

    // Record storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= {rec_evt, bx};
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef L1A_DROP_CNT_EN
    // Saturating count of every rejected trigger
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                  dropped <= '0;
        else if (l1a && !accept && dropped != 16'hFFFF) dropped <= dropped + 16'd1;
    end
`else
    assign dropped = '0;
`endif

endmodule

// File: tb/tb_l1a_trigger_buffer.sv
// Directed bench for l1a_trigger_buffer with default parameters.
module tb_l1a_trigger_buffer;

    localparam int BX_MAX = 3563;
`ifdef L1A_DROP_CNT_EN
    localparam int DROP_ON = 1;
`else
    localparam int DROP_ON = 0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        bc0 = 1'b0, ecr = 1'b0, l1a = 1'b0, out_ready = 1'b0;
    logic        out_valid, synced, bx_err, full;
    logic [23:0] out_evt;
    logic [11:0] out_bx;
    logic [4:0]  count;
    logic [15:0] dropped;

    int checks = 0, errors = 0;
    int cur_bx = 0;
    int m_drop = 0;
    int ebx [16];

    l1a_trigger_buffer dut (
        .clk(clk), .rst(rst), .bc0(bc0), .ecr(ecr), .l1a(l1a),
        .out_valid(out_valid), .out_ready(out_ready), .out_evt(out_evt),
        .out_bx(out_bx), .synced(synced), .bx_err(bx_err), .full(full),
        .count(count), .dropped(dropped)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic bc0, ecr, l1a, rdy;
        logic vld;
        int   cnt, evt, bx;
        logic syn;
        int   drp;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance past the edge, track the BX register
    task automatic cyc(input logic b, input logic e, input logic t, input logic r);
        bc0 = b; ecr = e; l1a = t; out_ready = r;
        @(posedge clk); #1;
        cur_bx = (b || cur_bx == BX_MAX) ? 0 : cur_bx + 1;
        bc0 = 1'b0; ecr = 1'b0; l1a = 1'b0;
    endtask

    task automatic idle_to(input int target, input logic r);
        for (int k = 0; k < 4000 && cur_bx != target; k++) cyc(0, 0, 0, r);
        chk("bx_reach", cur_bx, target);
    endtask

    initial begin
        //            bc0 ecr l1a rdy | vld cnt evt bx syn drp
        tbl[0]  = '{1, 0, 1, 0, 0, 0, 0, 0,  1, 1};
        tbl[1]  = '{0, 0, 1, 0, 1, 1, 0, 0,  1, 1};
        tbl[2]  = '{0, 0, 1, 0, 1, 1, 0, 0,  1, 2};
        tbl[3]  = '{0, 0, 1, 0, 1, 1, 0, 0,  1, 3};
        tbl[4]  = '{0, 0, 1, 0, 1, 2, 0, 0,  1, 3};
        tbl[5]  = '{0, 0, 0, 1, 1, 1, 1, 3,  1, 3};
        tbl[6]  = '{0, 0, 0, 1, 0, 0, 0, 0,  1, 3};
        tbl[7]  = '{0, 1, 1, 0, 1, 1, 0, 6,  1, 3};
        tbl[8]  = '{0, 0, 0, 1, 0, 0, 0, 0,  1, 3};
        tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0,  1, 3};
        tbl[10] = '{0, 0, 1, 0, 1, 1, 1, 9,  1, 3};
        tbl[11] = '{0, 0, 1, 1, 0, 0, 0, 0,  1, 4};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0,  1, 4};
        tbl[13] = '{0, 0, 1, 0, 1, 1, 2, 12, 1, 4};
        tbl[14] = '{0, 0, 0, 0, 1, 1, 2, 12, 1, 4};
        tbl[15] = '{0, 0, 0, 0, 1, 1, 2, 12, 1, 4};
        tbl[16] = '{0, 0, 1, 1, 1, 1, 3, 15, 1, 4};
        tbl[17] = '{0, 0, 0, 1, 0, 0, 0, 0,  1, 4};

        // Reset state
        #3;
        chk("rst_valid", out_valid, 0);
        chk("rst_evt", out_evt, 0);
        chk("rst_bx", out_bx, 0);
        chk("rst_synced", synced, 0);
        chk("rst_bxerr", bx_err, 0);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_dropped", dropped, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
        chk("unsync_synced", synced, 0);

        // Sync, capture, holdoff, ecr, push+pop vectors
        foreach (tbl[i]) begin
            cyc(tbl[i].bc0, tbl[i].ecr, tbl[i].l1a, tbl[i].rdy);
            chk($sformatf("t%0d_valid", i), out_valid, tbl[i].vld);
            chk($sformatf("t%0d_count", i), count, tbl[i].cnt);
            chk($sformatf("t%0d_synced", i), synced, tbl[i].syn);
            chk($sformatf("t%0d_dropped", i), dropped, tbl[i].drp * DROP_ON);
            chk($sformatf("t%0d_bxerr", i), bx_err, 0);
            if (tbl[i].vld) begin
                chk($sformatf("t%0d_evt", i), out_evt, tbl[i].evt);
                chk($sformatf("t%0d_bx", i), out_bx, tbl[i].bx);
            end
        end
        m_drop = 4;

        // Capture at bx=100, then the next accepted trigger
        idle_to(100, 1);
        cyc(0, 0, 1, 1);
        chk("cap100_valid", out_valid, 1);
        chk("cap100_evt", out_evt, 4);
        chk("cap100_bx", out_bx, 100);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
        chk("cap100_drained", out_valid, 0);
        cyc(0, 0, 1, 1);
        chk("next_evt", out_evt, 5);
        chk("next_bx", out_bx, 103);

        // BX wrap at BX_MAX
        idle_to(BX_MAX, 1);
        cyc(0, 0, 1, 1);
        chk("wrap_last_bx", out_bx, BX_MAX);
        chk("wrap_last_evt", out_evt, 6);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 1);
        chk("wrap_first_bx", out_bx, 2);
        chk("wrap_first_evt", out_evt, 7);

        // Aligned bc0 keeps bx_err clear, misaligned one sets it
        idle_to(BX_MAX, 1);
        cyc(1, 0, 0, 1);
        chk("bc0_aligned_err", bx_err, 0);
        chk("bc0_aligned_sync", synced, 1);
        idle_to(50, 1);
        cyc(1, 0, 0, 1);
        chk("bc0_mis_err", bx_err, 1);
        cyc(0, 0, 1, 1);
        chk("bc0_mis_bx", out_bx, 0);
        chk("bc0_mis_evt", out_evt, 8);
        cyc(0, 0, 0, 1);
        chk("bxerr_sticky", bx_err, 1);

        // Fill under backpressure, then drain in order
        cyc(0, 0, 0, 1); cyc(0, 1, 0, 1);
        for (int i = 0; i < 20; i++) begin
            if (i < 16) ebx[i] = cur_bx;
            else        m_drop++;
            cyc(0, 0, 1, 0);
            cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        end
        chk("full_count", count, 16);
        chk("full_flag", full, 1);
        chk("full_head_evt", out_evt, 0);
        chk("full_head_bx", out_bx, ebx[0]);
        chk("full_dropped", dropped, m_drop * DROP_ON);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_valid", i), out_valid, 1);
            chk($sformatf("drain%0d_evt", i), out_evt, i);
            chk($sformatf("drain%0d_bx", i), out_bx, ebx[i]);
            cyc(0, 0, 0, 1);
        end
        chk("drain_empty", out_valid, 0);
        chk("drain_full", full, 0);
        chk("drain_count", count, 0);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, 0);
            cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
        end
        chk("pre_rst_count", count, 5);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_synced", synced, 0);
        chk("mid_rst_bxerr", bx_err, 0);
        chk("mid_rst_dropped", dropped, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(0, 0, 1, 0);
        chk("post_rst_count", count, 0);
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_synced", synced, 0);
        chk("post_rst_dropped", dropped, DROP_ON);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
